// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter loading one shared clearable register, followed by a hold window
module reg_share_arbiter #(
  parameter int REQ_CNT = 4,
  parameter int DATA_WIDTH = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int SRC_W = ($clog2(REQ_CNT) < 1) ? 1 : $clog2(REQ_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_CNT-1:0]            req_valid,
  input  logic [REQ_CNT-1:0]            req_clear,
  input  logic [REQ_CNT*DATA_WIDTH-1:0] req_data,
  output logic [REQ_CNT-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_update,
  output logic [SRC_W-1:0]              out_src,
  output logic                          busy
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(REQ_CNT - 1);
  localparam logic [SRC_W:0] WRAP = (SRC_W + 1)'(REQ_CNT);
  state_t                r_state;
  logic [SRC_W-1:0]      r_ptr;
  logic [SRC_W-1:0]      r_src;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_update;
  logic                  w_found;
  logic [SRC_W-1:0]      w_idx;
  logic [REQ_CNT-1:0]    w_grant;
  logic [DATA_WIDTH-1:0] w_word;
  // scan from the pointer upward with wrap; first valid requester wins and its word is preselected
  always_comb begin
    logic [SRC_W:0]   w_sum;
    logic [SRC_W-1:0] w_cand;
    w_sum = '0;
    w_cand = '0;
    w_found = 1'b0;
    w_idx = '0;
    w_word = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      w_sum = {1'b0, r_ptr} + (SRC_W + 1)'(k);
      w_cand = SRC_W'((w_sum >= WRAP) ? w_sum - WRAP : w_sum);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx = w_cand;
      end
    end
    for (int i = 0; i < REQ_CNT; i++)
      if (SRC_W'(i) == w_idx)
        w_word = req_clear[i] ? '0 : req_data[i*DATA_WIDTH +: DATA_WIDTH];
    w_grant = (r_state == IDLE && !rst && w_found) ? {{(REQ_CNT-1){1'b0}}, 1'b1} << w_idx : '0;
  end
  // transfer loads the shared register and advances the pointer; HOLD counts down the settle window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_src    <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (r_state == HOLD) begin
        if (r_cnt == 8'd0) r_state <= IDLE;
        else r_cnt <= r_cnt - 8'd1;
      end else if (w_found) begin
        r_data   <= w_word;
        r_src    <= w_idx;
        r_update <= 1'b1;
        r_ptr    <= (w_idx == LAST) ? '0 : w_idx + SRC_W'(1);
        if (HOLD_CYCLES > 0) begin
          r_state <= HOLD;
          r_cnt   <= HOLD_INIT;
        end
      end
    end
  end
  assign req_ready  = w_grant;
  assign out_data   = r_data;
  assign out_update = r_update;
  assign out_src    = r_src;
  assign busy       = (r_state == HOLD);
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed and random checks of two arbiters (hold 2 and hold 0) against a cycle-count model
module tb_reg_share_arbiter;
  logic clk, rst;
  logic [1:0][3:0]  va, cl, rdy;
  logic [1:0][31:0] da;
  logic [1:0][7:0]  od;
  logic [1:0][1:0]  os;
  logic [1:0]       ou, bz;
  int n_chk = 0, n_err = 0;
  int hc[2] = '{2, 0};
  int ptr[2], since[2], msrc[2];
  logic [7:0] mdata[2];
  bit mupd[2];
  int q[$];

  reg_share_arbiter #(.REQ_CNT(4), .DATA_WIDTH(8), .HOLD_CYCLES(2)) u_h2 (
    .clk(clk), .rst(rst), .req_valid(va[0]), .req_clear(cl[0]), .req_data(da[0]),
    .req_ready(rdy[0]), .out_data(od[0]), .out_update(ou[0]), .out_src(os[0]), .busy(bz[0]));
  reg_share_arbiter #(.REQ_CNT(4), .DATA_WIDTH(8), .HOLD_CYCLES(0)) u_h0 (
    .clk(clk), .rst(rst), .req_valid(va[1]), .req_clear(cl[1]), .req_data(da[1]),
    .req_ready(rdy[1]), .out_data(od[1]), .out_update(ou[1]), .out_src(os[1]), .busy(bz[1]));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0;
      since[d] = 1000;
      msrc[d] = 0;
      mdata[d] = 0;
      mupd[d] = 0;
    end
  endfunction

  // a grant is allowed once more than H cycles have passed since the last transfer
  function automatic int pick(int d);
    if (rst || since[d] <= hc[d]) return -1;
    for (int o = 0; o < 4; o++)
      if (va[d][(ptr[d] + o) % 4]) return (ptr[d] + o) % 4;
    return -1;
  endfunction

  task automatic tick();
    int g[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      g[d] = pick(d);
      chk($sformatf("ready%0d", d), rdy[d], g[d] < 0 ? 0 : 1 << g[d]);
      chk($sformatf("data%0d", d), od[d], mdata[d]);
      chk($sformatf("src%0d", d), os[d], msrc[d]);
      chk($sformatf("update%0d", d), ou[d], mupd[d]);
      chk($sformatf("busy%0d", d), bz[d], since[d] >= 1 && since[d] <= hc[d]);
      if (g[d] >= 0) begin
        mdata[d] = cl[d][g[d]] ? 8'h00 : da[d][g[d]*8 +: 8];
        msrc[d] = g[d];
        mupd[d] = 1;
        ptr[d] = (g[d] + 1) % 4;
        since[d] = 1;
      end else begin
        mupd[d] = 0;
        if (since[d] < 1000) since[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), rdy[d], 0);
      chk($sformatf("rst_data%0d", d), od[d], 0);
      chk($sformatf("rst_src%0d", d), os[d], 0);
      chk($sformatf("rst_update%0d", d), ou[d], 0);
      chk($sformatf("rst_busy%0d", d), bz[d], 0);
    end
  endtask

  task automatic rst_pulse();
    rst = 1;
    mreset();
    #1;
    zero_chk();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    clk = 0; rst = 1; va = '0; cl = '0; da = '0;
    mreset();
    #1;
    zero_chk();
    @(posedge clk);
    #1;
    rst = 0;
    va[0] = 4'b0001; da[0][7:0] = 8'h5A;
    tick();
    va[0] = 0;
    tick();
    chk("d5a", od[0], 8'h5A);
    rst_pulse();
    va[0] = 4'b0100; da[0][23:16] = 8'h33;
    #1;
    chk("gnt2", rdy[0], 4'b0100);
    tick();
    va[0] = 0;
    chk("d33", od[0], 8'h33);
    chk("s33", os[0], 2);
    chk("u33", ou[0], 1);
    repeat (3) tick();
    rst_pulse();
    va[0] = 4'hF; da[0] = 32'h13121110;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (ou[0]) q.push_back(int'(os[0]));
    end
    va[0] = 0;
    chk("rr_cnt", q.size(), 5);
    for (int i = 0; i < 5 && i < q.size(); i++) chk($sformatf("rr%0d", i), q[i], i % 4);
    repeat (3) tick();
    va[0] = 4'b0001; da[0][7:0] = 8'h77;
    tick();
    va[0] = 0;
    repeat (2) tick();
    chk("d77", od[0], 8'h77);
    va[0] = 4'b0010; cl[0] = 4'b0010; da[0][15:8] = 8'hFF;
    tick();
    va[0] = 0; cl[0] = 0;
    chk("clr_d", od[0], 0);
    chk("clr_s", os[0], 1);
    chk("clr_u", ou[0], 1);
    repeat (2) tick();
    cl[0] = 4'hF;
    repeat (4) tick();
    chk("clr_nv", od[0], 0);
    cl[0] = 0;
    rst_pulse();
    va[0] = 4'b0100;
    tick();
    va[0] = 0;
    repeat (2) tick();
    va[0] = 4'b0010;
    tick();
    chk("wrap1", os[0], 1);
    va[0] = 0;
    repeat (2) tick();
    va[0] = 4'b1001;
    tick();
    chk("skip3", os[0], 3);
    repeat (3) tick();
    chk("skip0", os[0], 0);
    va[0] = 0;
    repeat (3) tick();
    va[0] = 4'b0001;
    tick();
    va[0] = 4'b1000;
    tick();
    rst_pulse();
    #1;
    chk("pend_rdy", rdy[0], 4'b1000);
    tick();
    chk("pend_src", os[0], 3);
    va[0] = 0;
    repeat (3) tick();
    q.delete();
    va[1] = 4'b0101;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (ou[1]) q.push_back(int'(os[1]));
    end
    va[1] = 0;
    chk("h0_cnt", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) chk($sformatf("h0_%0d", i), q[i], (i % 2) * 2);
    for (int t = 0; t < 400; t++) begin
      for (int d = 0; d < 2; d++) begin
        va[d] = 4'($urandom);
        cl[d] = 4'($urandom & $urandom);
        da[d] = $urandom;
      end
      if ($urandom_range(0, 49) == 0) rst_pulse();
      else tick();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one clearable data register between `REQ_CNT` requesters. Each requester offers a word (or a clear request) over a valid/ready handshake. The arbiter grants one requester per transfer, loads the shared register with that word (or zero when clear is requested), and then enforces a programmable settle/hold window before the next grant. It sits in front of register-style datapath elements whose consumers need a stable value for a minimum number of cycles after every update.

## Interface
- `REQ_CNT`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: width of the shared register and of each requester word.
- `HOLD_CYCLES`, default 2: idle cycles after each update during which no grant is issued; 0..255.
- `SRC_W`, derived as max(1, clog2(REQ_CNT)); not user-set.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  REQ_CNT  bit i: requester i offers a transfer.
- `req_clear`  in  REQ_CNT  bit i: requester i's transfer loads zero instead of data.
- `req_data`  in  REQ_CNT*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  REQ_CNT  one-hot or zero; bit i: requester i is granted this cycle.
- `out_data`  out  DATA_WIDTH  shared register contents.
- `out_update`  out  1  one-cycle pulse: `out_data` changed source this cycle.
- `out_src`  out  SRC_W  index of the requester that produced current `out_data`.
- `busy`  out  1  high while in HOLD state.

## Operation
- Reset (async assert): state=IDLE, rr pointer=0, hold counter=0, `out_data`=0, `out_update`=0, `out_src`=0, `req_ready`=0, `busy`=0. `req_ready` is forced 0 whenever `rst` is high.
- States: IDLE, HOLD.
- IDLE: `req_ready` is combinational. It grants the first requester with `req_valid` set, scanning from the rr pointer upward and wrapping at REQ_CNT-1 to 0. No valid requester means no grant.
- Transfer occurs when `req_valid[i] & req_ready[i]`. At the next edge:
  - `out_data` <= `req_clear[i]` ? 0 : word i. Clear has priority over data.
  - `out_src` <= i.
  - `out_update` <= 1.
  - rr pointer <= (i+1) mod REQ_CNT.
  - If HOLD_CYCLES>0: state <= HOLD and counter <= HOLD_CYCLES-1. Otherwise stay in IDLE.
- HOLD: `req_ready`=0 and `busy`=1. The counter decrements each cycle. When the counter is 0, state <= IDLE at the next edge.
- `out_update` is 0 in every cycle that does not directly follow a transfer.
- `out_data` and `out_src` hold their value between transfers.
- `req_valid` may deassert without a transfer; no state changes. `req_clear` and `req_data` are sampled only in the transfer cycle.
- `req_clear` without `req_valid` is ignored.

## Timing
- Grant latency: 0 cycles. `req_ready` is asserted in the same cycle as `req_valid` when in IDLE.
- Data latency: transfer in cycle N gives `out_data`/`out_src`/`out_update` valid in cycle N+1.
- With HOLD_CYCLES=H>0:
  - `busy` is high in cycles N+1 .. N+H.
  - The next grant can occur in cycle N+H+1.
  - Transfer spacing is H+1 cycles.
- With H=0, back-to-back transfers occur every cycle. The pointer advances each cycle, so continuous requesters rotate fairly.
- Simultaneous requests: exactly one grant. Losers see `req_ready`=0 and must hold `req_valid`.
- Wrap-around: pointer at REQ_CNT-1, with a grant to REQ_CNT-1, moves the pointer to 0.
- Reset mid-HOLD or mid-transfer: async return to the reset values above. A transfer whose edge coincides with `rst` is discarded.
- Starvation bound: a requester holding `req_valid` is granted within REQ_CNT transfers.

## Test plan
All scenarios use REQ_CNT=4, DATA_WIDTH=8, HOLD_CYCLES=2.
- **Reset values:** assert `rst` mid-run with `out_data`=0x5A -> immediately `out_data`=0, `out_src`=0, `req_ready`=0, `busy`=0. After release, a single request from 2 with 0x33 -> `req_ready`=0b0100 the same cycle; next cycle `out_data`=0x33, `out_src`=2, `out_update`=1.
- **Round-robin and hold window:** all four valid, data 0x10/0x11/0x12/0x13 -> grants in order 0,1,2,3,0. `out_data` sequence 0x10, 0x11, 0x12, 0x13 at 3-cycle spacing. `busy` high exactly 2 cycles after each update; `req_ready`=0 throughout.
- **Clear priority:** requester 1 with `req_clear`=1 and data 0xFF after `out_data`=0x77 -> `out_data`=0x00, `out_src`=1, `out_update`=1. `req_clear`=1 with `req_valid`=0 -> no change.
- **Wrap and skip:** pointer=3 and only requester 1 valid -> requester 1 granted, pointer becomes 2. Then requesters 0 and 3 valid -> 3 granted first, then 0.
- **Reset mid-HOLD:** `rst` pulsed one cycle after an update -> `busy`=0. On the first cycle after release, a pending request is granted immediately with `out_src` reflecting that requester.
- **HOLD_CYCLES=0 variant:** requesters 0 and 2 continuously valid -> `out_update` high every cycle and `out_src` alternating 0, 2, 0, 2.
